// File: rtl/loa_pkg.sv
// Shared constants and FSM state encoding for the lower-part-OR adder error monitor.
package loa_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;
  localparam int ACC_W_DEF = 48;
  localparam int ED_W      = WIDTH_DEF + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    RUN   = S_RUN,
    DRAIN = S_DRAIN,
    DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/loa_ed_calc.sv
// Combinational error distance between the exact sum a+b and an approximate sum.
module loa_ed_calc
  import loa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s_apx,
  output logic [WIDTH:0]   ed
);

  logic [WIDTH:0] exact;
  logic [WIDTH:0] apx;

  // Exact sum keeps its carry; the approximate sum is a plain WIDTH-bit value.
  assign exact = {1'b0, a} + {1'b0, b};
  assign apx   = {1'b0, s_apx};
  assign ed    = (exact >= apx) ? (exact - apx) : (apx - exact);

endmodule

// File: rtl/loa_err_mon.sv
// Windowed error statistics monitor for a lower-part-OR approximate adder:
// two-stage pipeline (capture, then error distance and accumulate) under a small FSM.
module loa_err_mon
  import loa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s_apx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [WIDTH:0]   max_ed
);

  localparam int EW = WIDTH + 1;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [EW-1:0]    ed);
    logic [ACC_W:0] full;
    full = {1'b0, acc} + (ACC_W+1)'(ed);
    return full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];
  endfunction

  state_t           state;
  logic [CNT_W-1:0] win_len_q;
  logic             start_ok;
  logic             accept;
  logic             last_acc;

  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [WIDTH-1:0] s_p1;
  logic             vld_p1;
  logic [EW-1:0]    ed_p1;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign in_ready = (state == RUN) && (sample_cnt < win_len_q);
  assign accept   = in_valid && in_ready;
  assign last_acc = accept && (sample_cnt == (win_len_q - CNT_W'(1)));
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      win_len_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            win_len_q <= win_len;
            state     <= (win_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (last_acc) state <= DRAIN;
        end
        // Stage 1 holds exactly one sample here; it retires on this edge.
        DRAIN:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage 1: capture accepted sample ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1 <= a;
      b_p1 <= b;
      s_p1 <= s_apx;
    end
  end

  // ---- stage 2: error distance and statistics update ----
  loa_ed_calc #(
    .WIDTH (WIDTH)
  ) u_ed_calc (
    .a     (a_p1),
    .b     (b_p1),
    .s_apx (s_p1),
    .ed    (ed_p1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
    end else if (start_ok) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
    end else begin
      if (accept) sample_cnt <= sample_cnt + CNT_W'(1);
      if (vld_p1) begin
        err_cnt <= err_cnt + CNT_W'(ed_p1 != '0);
        sum_ed  <= sat_add(sum_ed, ed_p1);
        if (ed_p1 > max_ed) max_ed <= ed_p1;
      end
    end
  end

endmodule

// File: tb/tb_loa_err_mon.sv
// Scoreboard bench for loa_err_mon: expected window statistics are queued as samples are driven
// and compared when done rises; a second instance with a 34-bit accumulator exercises saturation.
module tb_loa_err_mon;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;
  localparam int ACC_W = 48;
  localparam int SAT_W = 34;

  typedef struct packed {
    logic [15:0] cnt;
    logic [15:0] errs;
    logic [63:0] sum;
    logic [32:0] max;
  } stats_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] win_len = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] s_apx = '0;

  logic             in_ready, busy, done;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [ACC_W-1:0] sum_ed;
  logic [WIDTH:0]   max_ed;

  logic             sat_in_ready, sat_busy, sat_done;
  logic [CNT_W-1:0] sat_sample_cnt, sat_err_cnt;
  logic [SAT_W-1:0] sat_sum_ed;
  logic [WIDTH:0]   sat_max_ed;

  stats_t exp_q[$];
  stats_t cur;
  int     checks = 0;
  int     errors = 0;

  loa_err_mon #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .s_apx(s_apx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_ed(sum_ed), .max_ed(max_ed)
  );

  loa_err_mon #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .in_valid(in_valid), .in_ready(sat_in_ready), .a(a), .b(b), .s_apx(s_apx),
    .busy(sat_busy), .done(sat_done), .sample_cnt(sat_sample_cnt), .err_cnt(sat_err_cnt),
    .sum_ed(sat_sum_ed), .max_ed(sat_max_ed)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] model_ed(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] s);
    logic [63:0] e, t;
    e = {32'h0, x} + {32'h0, y};
    t = {32'h0, s};
    return (e >= t) ? 33'(e - t) : 33'(t - e);
  endfunction

  function automatic stats_t to_stats();
    stats_t o;
    o.cnt  = sample_cnt;
    o.errs = err_cnt;
    o.sum  = {16'h0, sum_ed};
    o.max  = max_ed;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_add(input logic [31:0] x, input logic [31:0] y, input logic [31:0] s);
    logic [32:0] ed;
    ed = model_ed(x, y, s);
    cur.cnt = cur.cnt + 16'd1;
    if (ed != 33'h0) cur.errs = cur.errs + 16'd1;
    cur.sum = cur.sum + {31'h0, ed};
    if (ed > cur.max) cur.max = ed;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] len);
    start = 1'b1;
    win_len = len;
    tick();
    start = 1'b0;
  endtask

  // Presents one sample and holds it until an edge accepts it; in_valid stays high afterwards.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] s,
                      output bit ok);
    in_valid = 1'b1;
    a = x;
    b = y;
    s_apx = s;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) begin
        model_add(x, y, s);
        ok = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    stats_t obs;
    #2 rst_n = 1'b0;
    #1;
    obs = to_stats();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || obs !== '0) begin
      errors++;
      $display("FAIL reset_async: busy=%b done=%b in_ready=%b stats=%h, expected all zero",
               busy, done, in_ready, obs);
    end
    tick();
    tick();
    obs = to_stats();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || obs !== '0) begin
      errors++;
      $display("FAIL reset_held: busy=%b done=%b in_ready=%b stats=%h, expected all zero",
               busy, done, in_ready, obs);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    stats_t exp, obs, snap;
    cur = '0;
    do_start(16'd1);
    send(32'h0000_8000, 32'h0000_8000, 32'h0001_8000, ok);
    in_valid = 1'b0;
    exp_q.push_back(cur);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_accept: sample not accepted within budget");
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_drain: done=%b busy=%b, expected done=0 busy=1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: done=%b busy=%b, expected done=1 busy=0", done, busy);
    end
    exp = exp_q.pop_front();
    obs = to_stats();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL single_stats: got %h expected %h", obs, exp);
    end
    checks++;
    if (sample_cnt !== 16'd1 || err_cnt !== 16'd1 || sum_ed !== 48'h8000 || max_ed !== 33'h8000) begin
      errors++;
      $display("FAIL single_const: cnt=%h err=%h sum=%h max=%h, expected 1 1 8000 8000",
               sample_cnt, err_cnt, sum_ed, max_ed);
    end
    snap = obs;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      tick();
      checks++;
      if (to_stats() !== snap || done !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL done_hold: stats=%h done=%b in_ready=%b, expected %h 1 0",
                 to_stats(), done, in_ready, snap);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok, all_ok;
    stats_t exp, obs;
    logic [31:0] xs[3] = '{32'h1, 32'hFF, 32'hFFFF_FFFF};
    logic [31:0] ys[3] = '{32'h2, 32'h1, 32'hFFFF_FFFF};
    logic [31:0] ss[3] = '{32'h3, 32'hFF, 32'hFFFF_FFFF};
    cur = '0;
    all_ok = 1'b1;
    do_start(16'd3);
    for (int i = 0; i < 3; i++) begin
      send(xs[i], ys[i], ss[i], ok);
      all_ok = all_ok & ok;
    end
    in_valid = 1'b0;
    exp_q.push_back(cur);
    tick();
    checks++;
    if (!all_ok || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: accepted=%b done=%b, expected 1 1", all_ok, done);
    end
    exp = exp_q.pop_front();
    obs = to_stats();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL b2b_stats: got %h expected %h", obs, exp);
    end
    checks++;
    if (sample_cnt !== 16'd3 || err_cnt !== 16'd2 || sum_ed !== 48'h1_0000_0000 ||
        max_ed !== 33'h0_FFFF_FFFF) begin
      errors++;
      $display("FAIL b2b_const: cnt=%h err=%h sum=%h max=%h, expected 3 2 100000000 ffffffff",
               sample_cnt, err_cnt, sum_ed, max_ed);
    end
  endtask

  task automatic test_zero_len();
    stats_t exp, obs;
    cur = '0;
    exp_q.push_back(cur);
    do_start(16'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_done: done=%b busy=%b in_ready=%b, expected 1 0 0",
               done, busy, in_ready);
    end
    exp = exp_q.pop_front();
    obs = to_stats();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL zero_len_stats: got %h expected %h", obs, exp);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b0 || done !== 1'b1 || sample_cnt !== 16'd0) begin
        errors++;
        $display("FAIL zero_len_ready: in_ready=%b done=%b cnt=%h, expected 0 1 0",
                 in_ready, done, sample_cnt);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gaps();
    stats_t exp, obs;
    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int acc;
    cur = '0;
    acc = 0;
    do_start(16'd4);
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      a = $urandom;
      b = $urandom;
      s_apx = a | b;
      start = (i == 2);
      win_len = 16'd9;
      if (in_valid && in_ready) begin
        model_add(a, b, s_apx);
        acc++;
      end
      tick();
      if (i < 6) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL gaps_busy: cycle %0d busy=%b, expected 1", i, busy);
        end
      end
    end
    start = 1'b0;
    in_valid = 1'b1;
    exp_q.push_back(cur);
    checks++;
    if (acc != 4 || in_ready !== 1'b0 || sample_cnt !== 16'd4) begin
      errors++;
      $display("FAIL gaps_accepts: accepts=%0d in_ready=%b cnt=%h, expected 4 0 4",
               acc, in_ready, sample_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL gaps_done: done=%b in_ready=%b, expected 1 0", done, in_ready);
    end
    exp = exp_q.pop_front();
    obs = to_stats();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL gaps_stats: got %h expected %h", obs, exp);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok, ok2;
    stats_t exp, obs;
    cur = '0;
    do_start(16'd5);
    send($urandom, $urandom, $urandom, ok);
    send($urandom, $urandom, $urandom, ok2);
    #3 rst_n = 1'b0;
    #1;
    obs = to_stats();
    checks++;
    if (!(ok && ok2) || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || obs !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b in_ready=%b stats=%h, expected all zero",
               busy, done, in_ready, obs);
    end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    cur = '0;
    do_start(16'd1);
    send(32'h1234_5678, 32'h0F0F_0F0F, 32'h1F3F_5F7F, ok);
    in_valid = 1'b0;
    exp_q.push_back(cur);
    tick();
    checks++;
    if (!ok || done !== 1'b1) begin
      errors++;
      $display("FAIL reset_restart_done: accepted=%b done=%b, expected 1 1", ok, done);
    end
    exp = exp_q.pop_front();
    obs = to_stats();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_restart_stats: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_saturation();
    bit ok, all_ok;
    stats_t exp, obs;
    logic [SAT_W-1:0] prev, exp_sat;
    cur = '0;
    all_ok = 1'b1;
    prev = '0;
    do_start(16'd6);
    for (int i = 0; i < 6; i++) begin
      send(32'hFFFF_FFFF, 32'h0, 32'h0, ok);
      all_ok = all_ok & ok;
      checks++;
      if (sat_sum_ed < prev) begin
        errors++;
        $display("FAIL sat_monotonic: sample %0d sum=%h dropped below %h", i, sat_sum_ed, prev);
      end
      prev = sat_sum_ed;
    end
    in_valid = 1'b0;
    exp_q.push_back(cur);
    tick();
    exp = exp_q.pop_front();
    obs = to_stats();
    checks++;
    if (!all_ok || done !== 1'b1 || obs !== exp) begin
      errors++;
      $display("FAIL sat_wide_stats: got %h done=%b expected %h", obs, done, exp);
    end
    exp_sat = (exp.sum > 64'h3_FFFF_FFFF) ? {SAT_W{1'b1}} : exp.sum[SAT_W-1:0];
    checks++;
    if (sat_done !== 1'b1 || sat_sum_ed !== exp_sat || sat_max_ed !== exp.max) begin
      errors++;
      $display("FAIL sat_clamp: sum=%h max=%h done=%b expected %h %h 1",
               sat_sum_ed, sat_max_ed, sat_done, exp_sat, exp.max);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_len();
    test_gaps();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/loa_err_mon.md
LOA_ERR_MON -- requirements
Module: loa_err_mon

Interface
REQ-001 Parameter: WIDTH, default 32, operand/sum width.
REQ-002 Parameter: CNT_W, default 16, width of window length and counters.
REQ-003 Parameter: ACC_W, default 48, width of the error-distance accumulator.
REQ-004 Port: clk  in  1  single clock, all state on rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: start  in  1  one-cycle request to begin a measurement window.
REQ-007 Port: win_len  in  CNT_W  number of samples in the window, sampled on the accepted start.
REQ-008 Port: in_valid  in  1  operand/result sample valid.
REQ-009 Port: in_ready  out  1  monitor accepts a sample this cycle.
REQ-010 Port: a, b  in  WIDTH each  operands presented to the lower-part-OR adder.
REQ-011 Port: s_apx  in  WIDTH  approximate sum produced by the lower-part-OR adder for a, b.
REQ-012 Port: busy  out  1  window in progress.
REQ-013 Port: done  out  1  results valid and held.
REQ-014 Port: sample_cnt  out  CNT_W  samples accepted in the window.
REQ-015 Port: err_cnt  out  CNT_W  samples with nonzero error distance.
REQ-016 Port: sum_ed  out  ACC_W  saturating sum of error distances.
REQ-017 Port: max_ed  out  WIDTH+1  largest error distance in the window.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN, DONE; busy=1 in RUN and DRAIN only; done=1 in DONE only.
REQ-019 IDLE or DONE with start=1 SHALL latch win_len, clear all four statistics, and go to RUN; if win_len==0 it SHALL go to DONE instead, with zero statistics.
REQ-020 start SHALL be ignored in RUN and DRAIN.
REQ-021 in_ready SHALL be 1 only in RUN while sample_cnt < latched win_len. A sample is accepted when in_valid and in_ready are both 1.
REQ-022 Stage 1 SHALL register a, b, s_apx and a valid flag on acceptance; sample_cnt SHALL increment in the same cycle.
REQ-023 Stage 2 SHALL compute exact = a+b at WIDTH+1 bits, zero-extend s_apx, and form ed = |exact - s_apx| at WIDTH+1 bits.
REQ-024 Stage 2 SHALL update the statistics one cycle after acceptance: err_cnt += (ed!=0); sum_ed += ed, saturating at all-ones; max_ed = max(max_ed, ed).
REQ-025 When the last sample of the window is accepted, the FSM SHALL move RUN->DRAIN. DRAIN SHALL last exactly the cycles needed to retire stage 1, then move to DONE.
REQ-026 done SHALL rise exactly 2 cycles after the cycle in which the last sample was accepted.
REQ-027 In DONE the FSM SHALL hold all outputs stable until a new start is accepted.
REQ-028 Gaps in in_valid during RUN SHALL stall without corrupting statistics; there is no timeout.
REQ-029 Statistics SHALL accumulate exactly one update per accepted sample, with no duplicates or losses under back-to-back valid.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, clear pipeline valid flags, and set busy, done, in_ready and all statistics to 0; reset mid-window discards the window.
REQ-031 After rst_n deasserts, the first start SHALL be honoured no earlier than the following rising edge.

Structure
REQ-032 Package loa_pkg SHALL hold the state enum, the default WIDTH/CNT_W/ACC_W constants and ED_W=WIDTH+1.
REQ-033 Sub-module loa_ed_calc (combinational: a, b, s_apx -> ed) SHALL implement REQ-023; loa_err_mon instantiates it in stage 2.

Verification
REQ-034 start, win_len=1, a=b=0x00008000, s_apx=0x00018000 -> done 2 cycles after accept; sample_cnt=1, err_cnt=1, sum_ed=0x8000, max_ed=0x8000.
REQ-035 win_len=3, back-to-back samples (0x1,0x2,s=0x3), (0xFF,0x1,s=0xFF), (0xFFFFFFFF,0xFFFFFFFF,s=0xFFFFFFFF) -> err_cnt=2, sum_ed=0x100000000, max_ed=0xFFFFFFFF.
REQ-036 start with win_len=0 -> DONE next cycle, all statistics 0, in_ready never 1.
REQ-037 win_len=4 with in_valid toggling 1,0,0,1,1,0,1 and start pulsed during RUN -> start ignored, exactly 4 samples accepted, in_ready=0 after the 4th accept.
REQ-038 rst_n pulsed low mid-window after 2 accepts -> immediate IDLE with all outputs 0; a fresh start with win_len=1 completes normally.
REQ-039 Force sum_ed near saturation (ACC_W=34, repeated ed=0xFFFFFFFF) -> sum_ed clamps at all-ones and never wraps.
